dmem_wait_responder: RTL and testbench
======================================

Name: dmem_wait_responder

Overview:
- Data-memory responder at the far end of the pipeline's MEM-stage access interface.
- Accepts a single-word read or write from the MEM stage and completes it after a programmable number of wait states.
- Holds the pipeline with a stall output until the response cycle.
- Replaces the zero-latency data memory when the pipeline is exercised against slow memory.

Parameters:
- ADDR_W, 8: word-address width; storage is 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2: wait states per access; legal range 1..15; elaboration error outside this range.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_read  in  1  MEM_MemRead from the pipeline.
- req_write  in  1  MEM_MemWrite from the pipeline.
- req_addr  in  32  byte address (MEM_ALUOut).
- req_wdata  in  32  store data (MEM_rd2).
- stall  out  1  pipeline hold; freezes PC, IF/ID, ID/EX and EX/MEM while high.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  read data; valid only while resp_valid=1.
- addr_err  out  1  asserted with resp_valid when the access was illegal.

Behaviour:
- States: IDLE, WAIT, RESP. A 4-bit wait counter and request latches hold addr, wdata, rd/wr, and the illegal flag.
- IDLE:
  - stall = req_read | req_write (combinational).
  - On a clock edge with a request present: latch it, set cnt=WAIT_CYCLES-1, go to WAIT.
- WAIT:
  - stall=1.
  - cnt decrements each cycle. When cnt==0, go to RESP at the next edge.
  - A legal latched write is committed to the array on that same edge.
  - A legal read fetches array data into a resp_rdata register on that same edge.
- RESP:
  - stall=0, resp_valid=1, resp_rdata driven.
  - Unconditional return to IDLE.
  - The request still present during RESP is the one being completed and is ignored. The pipeline advances on the edge ending RESP.
- Timing, with the request first seen in cycle 0:
  - stall is high in cycles 0..WAIT_CYCLES.
  - resp_valid is high in cycle WAIT_CYCLES+1.
  - Total occupancy is WAIT_CYCLES+2 cycles per access.
- Request inputs must be held stable by the pipeline while stall=1. Changes during WAIT are ignored because latched values are used.
- Illegal access, which follows normal timing:
  - Conditions: req_addr[1:0]!=0, or req_addr[31:ADDR_W+2]!=0, or req_read & req_write both high.
  - Response: addr_err=1 with resp_valid, array unchanged, resp_rdata=0.
- Legal write: resp_rdata=0 and addr_err=0 in RESP.
- Word index = req_addr[ADDR_W+1:2].
- Outputs outside RESP: resp_valid=0, addr_err=0, resp_rdata=0.
- Reset (asynchronous, active-low):
  - State goes to IDLE, cnt=0, latches cleared, resp_rdata=0. With reset low, stall, resp_valid and addr_err are all 0.
  - Reset mid-WAIT drops the pending access; a pending write is never committed.
  - Array contents are not cleared by reset.
  - Array contents are undefined at power-up.
- Back-to-back accesses: a request present in the first IDLE cycle after RESP is accepted immediately. There is no dead cycle beyond RESP.

Decomposition:
- Shared package mips_mem_pkg holds:
  - State encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - WAIT_CNT_W=4.
  - The WAIT_CYCLES legal-range constants.
- One sub-module, dmem_array:
  - 2**ADDR_W x 32 storage.
  - Synchronous write with write-enable, index and data.
  - Asynchronous read.
  - No reset.
- FSM, counter, legality check and output registers stay in dmem_wait_responder.

Test Plan:
- Reset held low 3 cycles, then released with no request -> stall=0, resp_valid=0, addr_err=0, resp_rdata=0 throughout.
- WAIT_CYCLES=2: write 0xDEADBEEF to 0x10, then read 0x10 -> each access has stall high 3 cycles and resp_valid in the 4th; the read returns resp_rdata=0xDEADBEEF with addr_err=0.
- Back-to-back: write 0x1 to 0x0 and 0x2 to 0x4, then read 0x4 then 0x0 -> no gap cycles beyond RESP; reads return 0x2 then 0x1.
- Illegal accesses:
  - Write to 0x11 -> addr_err=1 with resp_valid and normal timing; a following read of 0x10 still returns the prior value.
  - Read of 0x400 with ADDR_W=8 -> addr_err=1, rdata=0.
  - req_read & req_write both high -> addr_err=1.
- Reset asserted in the 2nd WAIT cycle of a write of 0xCAFEF00D to 0x20 -> outputs go to 0 immediately; a later read of 0x20 returns the pre-reset value, not 0xCAFEF00D.
- WAIT_CYCLES=1 and WAIT_CYCLES=15 builds, single read -> stall high 2 and 16 cycles respectively; resp_valid is exactly one cycle.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared constants for the wait-state data-memory responder
package mips_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int WAIT_CNT_W      = 4;
    localparam int WAIT_CYCLES_MIN = 1;
    localparam int WAIT_CYCLES_MAX = 15;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - 2**ADDR_W x 32 storage, synchronous write, asynchronous read, no reset
module dmem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_wait_responder.sv
// rtl/dmem_wait_responder.sv - MEM-stage data memory that completes each access after WAIT_CYCLES wait states
module dmem_wait_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_err
);
    import mips_mem_pkg::*;

    if (WAIT_CYCLES < WAIT_CYCLES_MIN || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait_cycles
        $error("dmem_wait_responder: WAIT_CYCLES must be within 1..15");
    end

    logic [1:0]            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  ill_q, ill_d;
    logic [31:0]           rdata_q, rdata_d;

    logic        req_any;
    logic        req_illegal;
    logic        last_wait;
    logic        arr_we;
    logic [31:0] arr_rdata;

    assign req_any     = req_read | req_write;
    assign req_illegal = (req_addr[1:0] != 2'b00)
                       | ((req_addr >> (ADDR_W + 2)) != 32'd0)
                       | (req_read & req_write);

    // The final wait cycle is where the access actually touches the array.
    assign last_wait = (state_q == ST_WAIT) && (cnt_q == '0);
    assign arr_we    = last_wait && wr_q && !ill_q;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ill_d   = ill_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
                    idx_d   = req_addr[ADDR_W+1:2];
                    wdata_d = req_wdata;
                    rd_d    = req_read;
                    wr_d    = req_write;
                    ill_d   = req_illegal;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    rdata_d = (rd_q && !ill_q) ? arr_rdata : 32'd0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                // Request is still asserted here but belongs to the access being completed.
                state_d = ST_IDLE;
                rdata_d = 32'd0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ill_q   <= ill_d;
            rdata_q <= rdata_d;
        end
    end

    assign stall      = reset & (((state_q == ST_IDLE) & req_any) | (state_q == ST_WAIT));
    assign resp_valid = (state_q == ST_RESP);
    assign addr_err   = resp_valid & ill_q;
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb/tb_dmem_wait_responder.sv - self-checking bench for dmem_wait_responder
module tb_dmem_wait_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, addr_err;
    logic [31:0] resp_rdata;

    logic        rd1, rd15;
    logic [31:0] s_addr;
    logic        stall1, rv1, ae1, stall15, rv15, ae15;
    logic [31:0] rdata1, rdata15;

    dmem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .addr_err(addr_err)
    );

    dmem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset(reset), .req_read(rd1), .req_write(1'b0),
        .req_addr(s_addr), .req_wdata(32'd0), .stall(stall1),
        .resp_valid(rv1), .resp_rdata(rdata1), .addr_err(ae1)
    );

    dmem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(15)) dut_w15 (
        .clk(clk), .reset(reset), .req_read(rd15), .req_write(1'b0),
        .req_addr(s_addr), .req_wdata(32'd0), .stall(stall15),
        .resp_valid(rv15), .resp_rdata(rdata15), .addr_err(ae15)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: age counts cycles since the request was first seen.
    logic [31:0] model_mem [int];
    int          age = -1;
    logic        m_wr, m_legal, m_rd_known;
    logic [31:0] m_addr, m_wdata, m_exp_rdata;
    logic [31:0] last_rdata;
    logic        last_err;
    int          stall_cnt = 0;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            age = -1;
            check("rst_stall", {31'd0, stall}, 32'd0);
            check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            check("rst_addr_err", {31'd0, addr_err}, 32'd0);
            check("rst_resp_rdata", resp_rdata, 32'd0);
        end else begin
            if (age < 0 && (req_read || req_write)) begin
                age        = 0;
                m_wr       = req_write;
                m_addr     = req_addr;
                m_wdata    = req_wdata;
                m_legal    = (req_addr[1:0] == 2'b00) && (req_addr[31:10] == 22'd0) && !(req_read && req_write);
                m_rd_known = 1'b1;
                m_exp_rdata = 32'd0;
                if (m_legal && req_read) begin
                    if (model_mem.exists(int'(req_addr[9:2]))) m_exp_rdata = model_mem[int'(req_addr[9:2])];
                    else m_rd_known = 1'b0;
                end
            end
            if (stall) stall_cnt++;
            check("stall", {31'd0, stall}, {31'd0, (age >= 0 && age <= W)});
            check("resp_valid", {31'd0, resp_valid}, {31'd0, (age == W + 1)});
            check("addr_err", {31'd0, addr_err}, {31'd0, (age == W + 1) && !m_legal});
            if (age != W + 1) check("resp_rdata_idle", resp_rdata, 32'd0);
            else if (m_rd_known) check("resp_rdata", resp_rdata, m_exp_rdata);
            if (age == W + 1) begin
                if (m_wr && m_legal) model_mem[int'(m_addr[9:2])] = m_wdata;
                last_rdata = resp_rdata;
                last_err   = addr_err;
                age = -1;
            end else if (age >= 0) begin
                age++;
            end
        end
    end

    // Occupancy monitor for the WAIT_CYCLES=1 and 15 builds.
    logic mon_en = 1'b0;
    logic seen1 = 1'b0, seen15 = 1'b0;
    int   sc1 = 0, vc1 = 0, ec1 = 0, sc15 = 0, vc15 = 0, ec15 = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (stall1)  sc1++;
            if (rv1)     begin vc1++;  seen1  = 1'b1; end
            if (ae1)     ec1++;
            if (stall15) sc15++;
            if (rv15)    begin vc15++; seen15 = 1'b1; end
            if (ae15)    ec15++;
        end
    end

    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_read = r; req_write = w; req_addr = a; req_wdata = d;
        repeat (W + 2) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_read = 1'b0; req_write = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; req_read = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        rd1 = 1'b0; rd15 = 1'b0; s_addr = 32'h8;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle(3);

        stall_cnt = 0;
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        check("wr_stall_cycles", stall_cnt, 32'd3);
        stall_cnt = 0;
        access(1'b1, 1'b0, 32'h10, 32'd0);
        check("rd_stall_cycles", stall_cnt, 32'd3);
        check("rd_10_data", last_rdata, 32'hDEADBEEF);
        check("rd_10_err", {31'd0, last_err}, 32'd0);
        idle(1);

        access(1'b0, 1'b1, 32'h0, 32'h1);
        access(1'b0, 1'b1, 32'h4, 32'h2);
        access(1'b1, 1'b0, 32'h4, 32'd0);
        check("b2b_rd_4", last_rdata, 32'h2);
        access(1'b1, 1'b0, 32'h0, 32'd0);
        check("b2b_rd_0", last_rdata, 32'h1);
        idle(2);

        access(1'b0, 1'b1, 32'h11, 32'h55555555);
        check("misaligned_err", {31'd0, last_err}, 32'd1);
        access(1'b1, 1'b0, 32'h10, 32'd0);
        check("after_bad_wr", last_rdata, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h400, 32'd0);
        check("range_err", {31'd0, last_err}, 32'd1);
        check("range_rdata", last_rdata, 32'd0);
        access(1'b1, 1'b1, 32'h10, 32'h77777777);
        check("rdwr_err", {31'd0, last_err}, 32'd1);
        access(1'b1, 1'b0, 32'h10, 32'd0);
        check("after_rdwr", last_rdata, 32'hDEADBEEF);
        idle(1);

        access(1'b0, 1'b1, 32'h20, 32'h12345678);
        idle(1);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_stall", {31'd0, stall}, 32'd0);
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 req_write = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        idle(1);
        access(1'b1, 1'b0, 32'h20, 32'd0);
        check("rd_after_abort", last_rdata, 32'h12345678);
        idle(2);

        mon_en = 1'b1;
        rd1 = 1'b1; rd15 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (seen1)  rd1  = 1'b0;
            if (seen15) rd15 = 1'b0;
        end
        mon_en = 1'b0;
        check("w1_done", {31'd0, seen1}, 32'd1);
        check("w1_stall_cycles", sc1, 32'd2);
        check("w1_resp_cycles", vc1, 32'd1);
        check("w1_err_cycles", ec1, 32'd0);
        check("w15_done", {31'd0, seen15}, 32'd1);
        check("w15_stall_cycles", sc15, 32'd16);
        check("w15_resp_cycles", vc15, 32'd1);
        check("w15_err_cycles", ec15, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
